upower_wb_unit: RTL
===================

Name: upower_wb_unit

Overview:
- Write-side master for the uPOWER 32x64b register file: collects results from the ALU and load paths and drives the file's single write port (wr, reg_id_w, data_in).
- Per-source 1-entry holding buffers; round-robin arbitration when both sources collide.
- Per-register pending-write scoreboard so decode can stall on RAW hazards.
- Bypass output covers the edge at which the register file's registered read still returns the old value.

Parameters:
- N, 64, data width of one register.
- R, 32, number of architectural registers.
- ASIZE, $clog2(R) = 5, register id width.
- CNT_W, 2, width of the per-register outstanding-write counter (max 3 in flight per register).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU buffer can accept this cycle.
- alu_rd  in  ASIZE  ALU destination register.
- alu_data  in  N  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load buffer can accept this cycle.
- ld_rd  in  ASIZE  load destination register.
- ld_data  in  N  load data.
- iss_valid  in  1  decode issues an instruction that writes iss_rd.
- iss_rd  in  ASIZE  destination of the issuing instruction.
- iss_ready  out  1  low when the counter for iss_rd is saturated.
- busy  out  R  bit i = 1 while register i has an outstanding write.
- rf_wr  out  1  to register file wr.
- rf_wid  out  ASIZE  to register file reg_id_w.
- rf_wdata  out  N  to register file data_in.
- byp_valid, byp_rd, byp_data  out  1/ASIZE/N  copy of rf_wr/rf_wid/rf_wdata for operand forwarding.

Behaviour:
Reset:
- While rst = 1 at a posedge, clear all state: both buffers empty, rf_wr = 0, rf_wid = 0, rf_wdata = 0, all counters 0 (busy = 0), last_grant = ALU, so load wins the first collision.
- Byp outputs follow the rf outputs and are therefore also 0.
- Reset mid-operation discards buffered results with no write.
- rf_wr is never 1 in the cycle after a reset edge.

Handshake:
- Transfer on X_valid & X_ready at posedge.
- X_ready = buffer X empty OR buffer X granted this cycle, so one result per source per cycle is sustained with no bubble.
- X_ready does not depend on X_valid.

Arbitration (combinational on buffer state):
- Only one buffer full: that buffer is granted.
- Both full: grant the source opposite last_grant, then update last_grant to the winner.
- Neither full: no grant; last_grant holds.

Output stage (registered):
- On a grant: at the posedge, rf_wr <= 1, rf_wid <= entry rd, rf_wdata <= entry data, and the granted buffer empties unless refilled the same edge.
- No grant: rf_wr <= 0; rf_wid and rf_wdata hold.

Latency:
- Accept at edge k: rf_wr = 1 after edge k+1 if uncontended.
- Register file commits at edge k+2.

Scoreboard:
- inc(r) = iss_valid & iss_ready & iss_rd == r.
- dec(r) = rf_wr & rf_wid == r.
- Counter update: inc only → +1; dec only → -1; both → unchanged.
- busy[r] = (cnt[r] != 0).
- iss_ready = (cnt[iss_rd] != 2^CNT_W - 1).
- A dec when the counter is 0 is a producer protocol error: the counter stays at 0 and a simulation $error is raised.

Bypass:
- Decode must compare source ids with byp_rd while byp_valid = 1, because the register file's registered read at that edge returns the pre-write value.
- Both sources targeting the same rd: writes commit in grant order; the last grant wins.

Decomposition:
- Package upower_rf_pkg holds N, R, ASIZE and a packed wb_entry_t {rd[ASIZE], data[N]}; the register file shares it.
- Sub-module upower_wb_buf (1-entry valid/ready holding register, instantiated twice).
- Arbiter, output register and scoreboard stay inline.

Test Plan:
- Reset, then ALU-only stream: alu_valid with rd=3/data=0x11, rd=4/data=0x22 on consecutive cycles → rf_wr high two consecutive cycles with (3,0x11) then (4,0x22); alu_ready stays 1.
- Collision after reset: alu rd=5/0xA and ld rd=6/0xB in the same cycle → load written first (6,0xB), ALU next cycle (5,0xA); ld_ready=1 and alu_ready=0 in the stall cycle.
- Sustained collision for 6 cycles → grants strictly alternate, so each source gets 3 writes and neither starves.
- Scoreboard: issue rd=7 three times → cnt=3, iss_ready=0 for rd=7 but 1 for rd=8; three writes to rd=7 → busy[7] clears exactly at the edge after the third rf_wr.
- Simultaneous issue and write to rd=9 with cnt=1 → cnt stays 1, busy[9] stays 1.
- Reset asserted while both buffers are full and rf_wr=1 → rf_wr=0 and busy=0 after that edge; no further writes appear after rst deasserts.

Source files
------------

// File: rtl/upower_rf_pkg.sv
// upower_rf_pkg: shared sizes and types for the uPOWER register file and its write-back unit
package upower_rf_pkg;
  localparam int N = 64;
  localparam int R = 32;
  localparam int ASIZE = $clog2(R);
  localparam int CNT_W = 2;
  typedef logic [ASIZE-1:0] rid_t;
  typedef struct packed {
    rid_t rd;
    logic [N-1:0] data;
  } wb_entry_t;
  typedef enum logic {SRC_ALU = 1'b0, SRC_LD = 1'b1} src_e;
endpackage

// File: rtl/upower_wb_buf.sv
// upower_wb_buf: one-entry valid/ready holding register in front of the write port
module upower_wb_buf
  import upower_rf_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  wb_entry_t in_entry,
  input  logic      grant,
  output logic      full,
  output wb_entry_t entry
);
  // A granted entry leaves at this edge, so the slot can be refilled without a bubble
  assign in_ready = !full || grant;
  always_ff @(posedge clk)
    if (rst) full <= 1'b0;
    else if (in_valid && in_ready) full <= 1'b1;
    else if (grant) full <= 1'b0;
  always_ff @(posedge clk)
    if (in_valid && in_ready) entry <= in_entry;
endmodule

// File: rtl/upower_wb_unit.sv
// upower_wb_unit: arbitrates ALU/load results onto the register file write port and tracks pending writes
module upower_wb_unit
  import upower_rf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [ASIZE-1:0] alu_rd,
  input  logic [N-1:0]     alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [ASIZE-1:0] ld_rd,
  input  logic [N-1:0]     ld_data,
  input  logic             iss_valid,
  input  logic [ASIZE-1:0] iss_rd,
  output logic             iss_ready,
  output logic [R-1:0]     busy,
  output logic             rf_wr,
  output logic [ASIZE-1:0] rf_wid,
  output logic [N-1:0]     rf_wdata,
  output logic             byp_valid,
  output logic [ASIZE-1:0] byp_rd,
  output logic [N-1:0]     byp_data
);
  logic a_full, l_full, a_grant, l_grant;
  wb_entry_t a_entry, l_entry;
  src_e last_grant;
  logic [R-1:0] sat;
  upower_wb_buf u_alu (
    .clk(clk), .rst(rst), .in_valid(alu_valid), .in_ready(alu_ready),
    .in_entry({alu_rd, alu_data}), .grant(a_grant), .full(a_full), .entry(a_entry)
  );
  upower_wb_buf u_ld (
    .clk(clk), .rst(rst), .in_valid(ld_valid), .in_ready(ld_ready),
    .in_entry({ld_rd, ld_data}), .grant(l_grant), .full(l_full), .entry(l_entry)
  );
  // On a collision the source that lost last time wins
  assign l_grant = l_full && (!a_full || last_grant == SRC_ALU);
  assign a_grant = a_full && !l_grant;
  always_ff @(posedge clk)
    if (rst) begin
      rf_wr <= 1'b0;
      rf_wid <= '0;
      rf_wdata <= '0;
      last_grant <= SRC_ALU;
    end else begin
      rf_wr <= a_grant || l_grant;
      if (a_grant || l_grant) {rf_wid, rf_wdata} <= l_grant ? l_entry : a_entry;
      if (a_full && l_full) last_grant <= l_grant ? SRC_LD : SRC_ALU;
    end
  for (genvar i = 0; i < R; i++) begin : g_sb
    logic [CNT_W-1:0] cnt;
    logic inc, dec;
    assign inc = iss_valid && iss_ready && iss_rd == ASIZE'(i);
    assign dec = rf_wr && rf_wid == ASIZE'(i);
    always_ff @(posedge clk) begin
      assert (rst || !dec || cnt != '0) else $error("write to register %0d with no outstanding issue", i);
      if (rst) cnt <= '0;
      else if (inc && !dec) cnt <= cnt + 1'b1;
      else if (dec && !inc && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign busy[i] = |cnt;
    assign sat[i] = &cnt;
  end
  assign iss_ready = !sat[iss_rd];
  assign byp_valid = rf_wr;
  assign byp_rd = rf_wid;
  assign byp_data = rf_wdata;
endmodule
